// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage: FSM states, widths,
// and the byte-address to word-index mapping used by the data memory.
package mem_stage_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEST_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              ok;
    logic [WORD_W-1:0] idx;
  } addr_map_t;

  // Word index relative to base; low two address bits are dropped.
  function automatic addr_map_t map_addr(input logic [WORD_W-1:0] addr,
                                         input logic [WORD_W-1:0] base,
                                         input int unsigned       depth);
    addr_map_t        m;
    logic [WORD_W-1:0] off;
    off   = addr - base;
    m.idx = off >> 2;
    m.ok  = (addr >= base) && (m.idx < depth);
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read by byte
// address, reads of unmapped addresses return zero.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              in_range_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  addr_map_t         map;

  assign map        = map_addr(addr_i, WORD_W'(BASE_ADDR), DEPTH);
  assign in_range_o = map.ok;

  // Full-width index compare keeps out-of-range addresses from aliasing.
  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (map.ok && (map.idx == WORD_W'(i))) rdata_o = mem_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we_i && map.ok && (map.idx == WORD_W'(i))) mem_q[i] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: emulates a multi-cycle SRAM, freezing the
// upstream registers for WAIT_CYCLES cycles per load/store.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_In,
  input  logic              MEM_R_EN_In,
  input  logic              MEM_W_EN_In,
  input  logic [DEST_W-1:0] Dest_In,
  input  logic [WORD_W-1:0] ALU_Res_In,
  input  logic [WORD_W-1:0] Val_Rm_In,
  output logic              freeze,
  output logic              WB_EN_Out,
  output logic              MEM_R_EN_Out,
  output logic [DEST_W-1:0] Dest_Out,
  output logic [WORD_W-1:0] ALU_Res_Out,
  output logic [WORD_W-1:0] Mem_Data_Out
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] rbuf_q, rbuf_d;

  logic              req, busy;
  logic [WORD_W-1:0] mem_addr, mem_rdata;
  logic              mem_ok, mem_we;

  assign req = MEM_R_EN_In | MEM_W_EN_In;

  // In IDLE the live address feeds the memory so WAIT_CYCLES=1 can capture
  // read data on the same edge that latches the request.
  assign mem_addr = (state_q == S_IDLE) ? ALU_Res_In : addr_q;
  assign mem_we   = rst & (state_q == S_DONE) & wr_q & mem_ok;

  data_memory #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_mem (
    .clk_i      (clk),
    .we_i       (mem_we),
    .addr_i     (mem_addr),
    .wdata_i    (data_q),
    .rdata_o    (mem_rdata),
    .in_range_o (mem_ok)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rbuf_d  = rbuf_q;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          busy    = 1'b1;
          wr_d    = MEM_W_EN_In & ~MEM_R_EN_In;
          addr_d  = ALU_Res_In;
          data_d  = Val_Rm_In;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q == 4'd1) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) rbuf_d = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign freeze       = rst & busy;
  assign WB_EN_Out    = rst & ~busy & WB_EN_In;
  assign MEM_R_EN_Out = MEM_R_EN_In;
  assign Dest_Out     = Dest_In;
  assign ALU_Res_Out  = ALU_Res_In;
  assign Mem_Data_Out = rbuf_q;

endmodule
